mem_split_issue: RTL and testbench

- Sits directly downstream of the register-read/address-generation stage and consumes one memory operand per instruction: start address, inclusive end address, rw code and instruction ptcid.
- Decides whether the access crosses a cache-line boundary and issues one or two line-aligned requests to the data cache, with per-line byte masks.
- Back-pressures the upstream stage through stall while a request sequence is outstanding.

---
 rtl/mem_split_issue.sv | 152 +++++++++++++++
 tb/tb_mem_split_issue.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_split_issue.sv
// Memory operand issue stage: splits a line-crossing access into one or two
// line-aligned cache requests with byte masks, stalling upstream while busy.
module mem_split_issue #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned LINE_BITS  = 4
) (
    input  logic                        clk,
    input  logic                        clr,
    input  logic                        flush,
    input  logic                        valid_in,
    input  logic [ADDR_WIDTH-1:0]       mem_addr,
    input  logic [ADDR_WIDTH-1:0]       mem_addr_end,
    input  logic [1:0]                  rw_in,
    input  logic [6:0]                  ptcid_in,
    input  logic                        req_ready,
    output logic                        stall,
    output logic                        req_valid,
    output logic [ADDR_WIDTH-1:0]       req_addr,
    output logic [(1<<LINE_BITS)-1:0]   req_mask,
    output logic [1:0]                  req_rw,
    output logic [6:0]                  req_ptcid,
    output logic                        req_first,
    output logic                        req_last,
    output logic                        span_err
);

    localparam int unsigned LineBytes = 1 << LINE_BITS;
    localparam int unsigned LineWidth = ADDR_WIDTH - LINE_BITS;
    localparam logic [LINE_BITS-1:0] LastByte = '1;
    localparam logic [LineBytes-1:0] AllOnes  = '1;

    typedef enum logic [1:0] {StIdle, StReq0, StReq1} state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] sa_q, sa_d, ea_q, ea_d;
    logic [1:0]            rw_q, rw_d;
    logic [6:0]            ptcid_q, ptcid_d;
    logic                  split_q, split_d;
    logic                  span_err_q, span_err_d;

    logic [LineWidth-1:0]  line_diff;
    logic                  in_split, in_bad, accept, take, squash;
    logic [LINE_BITS-1:0]  mask_lo, mask_hi;

    // Modulo line difference so an access wrapping the top of memory is still a legal split.
    assign line_diff = mem_addr_end[ADDR_WIDTH-1:LINE_BITS] - mem_addr[ADDR_WIDTH-1:LINE_BITS];
    assign in_split  = (line_diff == LineWidth'(1));
    assign in_bad    = (line_diff > LineWidth'(1));
    assign squash    = clr | flush;
    assign accept    = (state_q == StIdle) | (req_valid & req_ready & req_last);
    assign take      = valid_in & accept & ~squash;
    assign stall     = valid_in & ~accept & ~squash;
    assign span_err  = span_err_q;

    always_comb begin
        state_d    = state_q;
        sa_d       = sa_q;
        ea_d       = ea_q;
        rw_d       = rw_q;
        ptcid_d    = ptcid_q;
        split_d    = split_q;
        span_err_d = 1'b0;

        unique case (state_q)
            StReq0: if (req_ready) state_d = split_q ? StReq1 : StIdle;
            StReq1: if (req_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase

        if (take) begin
            if (rw_in == 2'b00) begin
                state_d = StIdle;
            end else if (in_bad) begin
                state_d    = StIdle;
                span_err_d = 1'b1;
            end else begin
                state_d = StReq0;
                sa_d    = mem_addr;
                ea_d    = mem_addr_end;
                rw_d    = rw_in;
                ptcid_d = ptcid_in;
                split_d = in_split;
            end
        end

        if (squash) begin
            state_d    = StIdle;
            sa_d       = '0;
            ea_d       = '0;
            rw_d       = '0;
            ptcid_d    = '0;
            split_d    = 1'b0;
            span_err_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q    <= StIdle;
            sa_q       <= '0;
            ea_q       <= '0;
            rw_q       <= '0;
            ptcid_q    <= '0;
            split_q    <= 1'b0;
            span_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            sa_q       <= sa_d;
            ea_q       <= ea_d;
            rw_q       <= rw_d;
            ptcid_q    <= ptcid_d;
            split_q    <= split_d;
            span_err_q <= span_err_d;
        end
    end

    always_comb begin
        req_valid = 1'b0;
        req_addr  = '0;
        req_rw    = '0;
        req_ptcid = '0;
        req_first = 1'b0;
        req_last  = 1'b0;
        mask_lo   = '0;
        mask_hi   = '0;
        req_mask  = '0;
        unique case (state_q)
            StReq0: begin
                req_valid = 1'b1;
                req_addr  = {sa_q[ADDR_WIDTH-1:LINE_BITS], {LINE_BITS{1'b0}}};
                req_rw    = rw_q;
                req_ptcid = ptcid_q;
                req_first = 1'b1;
                req_last  = ~split_q;
                mask_lo   = sa_q[LINE_BITS-1:0];
                mask_hi   = split_q ? LastByte : ea_q[LINE_BITS-1:0];
                req_mask  = (AllOnes << mask_lo) & (AllOnes >> (LastByte - mask_hi));
            end
            StReq1: begin
                req_valid = 1'b1;
                req_addr  = {ea_q[ADDR_WIDTH-1:LINE_BITS], {LINE_BITS{1'b0}}};
                req_rw    = rw_q;
                req_ptcid = ptcid_q;
                req_last  = 1'b1;
                mask_hi   = ea_q[LINE_BITS-1:0];
                req_mask  = AllOnes >> (LastByte - mask_hi);
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_split_issue.sv
// Directed bench for mem_split_issue: hand-computed expectations checked
// with immediate assertions one step after each rising edge.
module tb_mem_split_issue;

    logic        clk = 1'b0;
    logic        clr, flush, valid_in, req_ready;
    logic [31:0] mem_addr, mem_addr_end;
    logic [1:0]  rw_in;
    logic [6:0]  ptcid_in;
    logic        stall, req_valid, req_first, req_last, span_err;
    logic [31:0] req_addr;
    logic [15:0] req_mask;
    logic [1:0]  req_rw;
    logic [6:0]  req_ptcid;

    int tests = 0;
    int fails = 0;

    mem_split_issue dut (
        .clk         (clk),
        .clr         (clr),
        .flush       (flush),
        .valid_in    (valid_in),
        .mem_addr    (mem_addr),
        .mem_addr_end(mem_addr_end),
        .rw_in       (rw_in),
        .ptcid_in    (ptcid_in),
        .req_ready   (req_ready),
        .stall       (stall),
        .req_valid   (req_valid),
        .req_addr    (req_addr),
        .req_mask    (req_mask),
        .req_rw      (req_rw),
        .req_ptcid   (req_ptcid),
        .req_first   (req_first),
        .req_last    (req_last),
        .span_err    (span_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] e,
                         input logic [1:0] rw, input logic [6:0] id);
        valid_in     = v;
        mem_addr     = a;
        mem_addr_end = e;
        rw_in        = rw;
        ptcid_in     = id;
        #1;
    endtask

    task automatic check_req(input string tag, input logic v, input logic [31:0] a,
                             input logic [15:0] m, input logic f, input logic l);
        check({tag, "_valid"}, 32'(req_valid), 32'(v));
        check({tag, "_addr"},  req_addr,       a);
        check({tag, "_mask"},  32'(req_mask),  32'(m));
        check({tag, "_first"}, 32'(req_first), 32'(f));
        check({tag, "_last"},  32'(req_last),  32'(l));
    endtask

    initial begin
        clr = 1'b1; flush = 1'b0; req_ready = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 2'b00, 7'd0);
        step(); step();
        check_req("rst", 1'b0, 32'h0, 16'h0, 1'b0, 1'b0);
        check("rst_stall", 32'(stall), 32'h0);
        check("rst_span",  32'(span_err), 32'h0);
        check("rst_rw",    32'(req_rw), 32'h0);
        check("rst_ptcid", 32'(req_ptcid), 32'h0);
        clr = 1'b0;
        step();

        // 1: aligned read
        req_ready = 1'b1;
        drive(1'b1, 32'h1000, 32'h1003, 2'b01, 7'd1);
        check("t1_stall", 32'(stall), 32'h0);
        check("t1_idle_valid", 32'(req_valid), 32'h0);
        step();
        drive(1'b0, 32'h0, 32'h0, 2'b00, 7'd0);
        check_req("t1", 1'b1, 32'h1000, 16'h000F, 1'b1, 1'b1);
        check("t1_rw", 32'(req_rw), 32'h1);
        check("t1_ptcid", 32'(req_ptcid), 32'h1);
        step();
        check_req("t1_done", 1'b0, 32'h0, 16'h0, 1'b0, 1'b0);

        // 2: split write, second operand waits then issues with no bubble
        drive(1'b1, 32'h100E, 32'h1011, 2'b10, 7'd5);
        step();
        drive(1'b1, 32'h2004, 32'h2007, 2'b01, 7'd9);
        check_req("t2_r0", 1'b1, 32'h1000, 16'hC000, 1'b1, 1'b0);
        check("t2_r0_rw", 32'(req_rw), 32'h2);
        check("t2_r0_stall", 32'(stall), 32'h1);
        step();
        check_req("t2_r1", 1'b1, 32'h1010, 16'h0003, 1'b0, 1'b1);
        check("t2_r1_ptcid", 32'(req_ptcid), 32'h5);
        check("t2_r1_stall", 32'(stall), 32'h0);
        step();
        drive(1'b0, 32'h0, 32'h0, 2'b00, 7'd0);
        check_req("t2_b2b", 1'b1, 32'h2000, 16'h00F0, 1'b1, 1'b1);
        check("t2_b2b_ptcid", 32'(req_ptcid), 32'h9);

        // 3: back-pressure in REQ0 with a pending operand
        req_ready = 1'b0;
        drive(1'b1, 32'h3000, 32'h3000, 2'b11, 7'd3);
        check("t3_stall0", 32'(stall), 32'h1);
        for (int i = 0; i < 3; i++) begin
            step();
            check_req("t3_hold", 1'b1, 32'h2000, 16'h00F0, 1'b1, 1'b1);
            check("t3_hold_ptcid", 32'(req_ptcid), 32'h9);
            check("t3_hold_stall", 32'(stall), 32'h1);
        end
        req_ready = 1'b1;
        #1;
        check("t3_release_stall", 32'(stall), 32'h0);
        step();
        drive(1'b0, 32'h0, 32'h0, 2'b00, 7'd0);
        check_req("t3_next", 1'b1, 32'h3000, 16'h0001, 1'b1, 1'b1);
        check("t3_next_rw", 32'(req_rw), 32'h3);
        step();
        check("t3_idle", 32'(req_valid), 32'h0);

        // 4: wrap-around split
        drive(1'b1, 32'hFFFF_FFFC, 32'h0000_0003, 2'b01, 7'd7);
        step();
        drive(1'b0, 32'h0, 32'h0, 2'b00, 7'd0);
        check_req("t4_r0", 1'b1, 32'hFFFF_FFF0, 16'hF000, 1'b1, 1'b0);
        step();
        check_req("t4_r1", 1'b1, 32'h0000_0000, 16'h000F, 1'b0, 1'b1);
        check("t4_span", 32'(span_err), 32'h0);
        step();
        check("t4_idle", 32'(req_valid), 32'h0);

        // 5: span error
        drive(1'b1, 32'h2000, 32'h2020, 2'b01, 7'd2);
        step();
        drive(1'b0, 32'h0, 32'h0, 2'b00, 7'd0);
        check("t5_span", 32'(span_err), 32'h1);
        check("t5_valid", 32'(req_valid), 32'h0);
        step();
        check("t5_span_off", 32'(span_err), 32'h0);
        check("t5_valid_off", 32'(req_valid), 32'h0);

        // 6a: flush in REQ1 while stalled; simultaneous operand is dropped
        drive(1'b1, 32'h100E, 32'h1011, 2'b10, 7'd4);
        step();
        drive(1'b0, 32'h0, 32'h0, 2'b00, 7'd0);
        step();
        req_ready = 1'b0;
        #1;
        check_req("t6_r1", 1'b1, 32'h1010, 16'h0003, 1'b0, 1'b1);
        flush = 1'b1;
        drive(1'b1, 32'h6000, 32'h6003, 2'b01, 7'd6);
        check("t6_flush_stall", 32'(stall), 32'h0);
        step();
        flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 2'b00, 7'd0);
        check_req("t6_flushed", 1'b0, 32'h0, 16'h0, 1'b0, 1'b0);
        step();
        check("t6_flush_dropped", 32'(req_valid), 32'h0);

        // 6b: rw none is consumed silently
        req_ready = 1'b1;
        drive(1'b1, 32'h4000, 32'h4003, 2'b00, 7'd8);
        check("t6_none_stall", 32'(stall), 32'h0);
        step();
        drive(1'b0, 32'h0, 32'h0, 2'b00, 7'd0);
        check("t6_none_valid", 32'(req_valid), 32'h0);
        check("t6_none_span", 32'(span_err), 32'h0);

        // 6c: clr mid-sequence
        req_ready = 1'b0;
        drive(1'b1, 32'h5000, 32'h5003, 2'b01, 7'd10);
        step();
        drive(1'b0, 32'h0, 32'h0, 2'b00, 7'd0);
        check("t6_clr_pre", 32'(req_valid), 32'h1);
        clr = 1'b1;
        step();
        clr = 1'b0;
        #1;
        check_req("t6_clr", 1'b0, 32'h0, 16'h0, 1'b0, 1'b0);
        check("t6_clr_rw", 32'(req_rw), 32'h0);
        check("t6_clr_ptcid", 32'(req_ptcid), 32'h0);
        check("t6_clr_stall", 32'(stall), 32'h0);
        step();
        check("t6_clr_stay", 32'(req_valid), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
